// File: rtl/score_bcd_converter_if.sv
// Score-to-BCD converter bus: request side (start, bin_in) and result side.
interface score_bcd_converter_if #(
    parameter int unsigned BIN_WIDTH = 24,
    parameter int unsigned DIGITS    = 6
);
    logic                   start;
    logic [BIN_WIDTH-1:0]   bin_in;
    logic                   busy;
    logic                   valid;
    logic [4*DIGITS-1:0]    bcd_out;
    logic [DIGITS-1:0]      digit_en;
    logic                   overflow;

    // Requester: game logic / testbench
    modport master (
        output start, bin_in,
        input  busy, valid, bcd_out, digit_en, overflow
    );

    // Converter
    modport slave (
        input  start, bin_in,
        output busy, valid, bcd_out, digit_en, overflow
    );
endinterface

// File: rtl/score_bcd_converter.sv
// Iterative double-dabble binary-to-BCD converter, one input bit per clock,
// with saturation at 10^DIGITS-1 and leading-zero blanking mask.
module score_bcd_converter #(
    parameter int unsigned BIN_WIDTH = 24,
    parameter int unsigned DIGITS    = 6
) (
    input  logic                   clk,
    input  logic                   reset,
    score_bcd_converter_if.slave   bus
);
    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CNT_W = (BIN_WIDTH > 1) ? $clog2(BIN_WIDTH) : 1;

    function automatic longint unsigned pow10(input int unsigned n);
        longint unsigned r;
        r = 64'd1;
        for (int unsigned i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

    localparam logic [BIN_WIDTH-1:0] MAX_VAL  = BIN_WIDTH'(pow10(DIGITS) - 64'd1);
    localparam logic [CNT_W-1:0]     LAST_CNT = CNT_W'(BIN_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [BIN_WIDTH-1:0]   shreg_q, shreg_d;
    logic [BCD_W-1:0]       bcd_q, bcd_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   sat_q, sat_d;
    logic                   busy_q, busy_d;
    logic                   valid_q, valid_d;
    logic [BCD_W-1:0]       bcd_out_q, bcd_out_d;
    logic [DIGITS-1:0]      digit_en_q, digit_en_d;
    logic                   overflow_q, overflow_d;

    logic [BCD_W-1:0]       bcd_corr;
    logic [DIGITS-1:0]      digit_nz;
    logic [DIGITS-1:0]      blank_mask;

    // Add-3 correction of every working digit >= 5, all from pre-shift values
    always_comb begin
        bcd_corr = bcd_q;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_corr[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // Digit i is shown when it or any more significant digit is nonzero; units always shown
    always_comb begin
        digit_nz   = '0;
        blank_mask = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            digit_nz[i] = |bcd_q[4*i +: 4];
        end
        for (int unsigned i = 0; i < DIGITS; i++) begin
            blank_mask[i] = |(digit_nz >> i);
        end
        blank_mask[0] = 1'b1;
    end

    // Next-state and output logic
    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        bcd_d      = bcd_q;
        cnt_d      = cnt_q;
        sat_d      = sat_q;
        busy_d     = busy_q;
        valid_d    = 1'b0;
        bcd_out_d  = bcd_out_q;
        digit_en_d = digit_en_q;
        overflow_d = overflow_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    sat_d   = (bus.bin_in > MAX_VAL);
                    shreg_d = (bus.bin_in > MAX_VAL) ? MAX_VAL : bus.bin_in;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                bcd_d   = {bcd_corr[BCD_W-2:0], shreg_q[BIN_WIDTH-1]};
                shreg_d = {shreg_q[BIN_WIDTH-2:0], 1'b0};
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                bcd_out_d  = bcd_q;
                digit_en_d = blank_mask;
                overflow_d = sat_q;
                valid_d    = 1'b1;
                busy_d     = 1'b0;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            sat_q      <= 1'b0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            bcd_out_q  <= '0;
            digit_en_q <= DIGITS'(1);
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            bcd_q      <= bcd_d;
            cnt_q      <= cnt_d;
            sat_q      <= sat_d;
            busy_q     <= busy_d;
            valid_q    <= valid_d;
            bcd_out_q  <= bcd_out_d;
            digit_en_q <= digit_en_d;
            overflow_q <= overflow_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.valid    = valid_q;
    assign bus.bcd_out  = bcd_out_q;
    assign bus.digit_en = digit_en_q;
    assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_score_bcd_converter.sv
// Scoreboard bench for score_bcd_converter: expected results are queued at
// each accepted start and compared when valid pulses.
module tb_score_bcd_converter;
    localparam int unsigned BW  = 24;
    localparam int unsigned DG  = 6;
    localparam int unsigned LAT = BW + 1;

    typedef struct {
        logic [23:0] bcd;
        logic [5:0]  en;
        logic        ovf;
        int          cyc;
    } exp_t;

    logic clk;
    logic reset;
    int   cyc;
    int   n_checks;
    int   n_fail;
    exp_t sb_q[$];

    score_bcd_converter_if #(.BIN_WIDTH(BW), .DIGITS(DG)) bus ();

    score_bcd_converter #(.BIN_WIDTH(BW), .DIGITS(DG)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference: decimal digits by division, saturated at 999999
    function automatic exp_t model(input int unsigned v, input int exp_cyc);
        exp_t        e;
        int unsigned x;
        int unsigned d;
        bit          seen;
        e.ovf = (v > 999999);
        x     = e.ovf ? 999999 : v;
        e.bcd = '0;
        for (int i = 0; i < 6; i++) begin
            d = x % 10;
            e.bcd[4*i +: 4] = 4'(d);
            x = x / 10;
        end
        seen = 1'b0;
        e.en = '0;
        for (int i = 5; i >= 0; i--) begin
            if (e.bcd[4*i +: 4] != 4'd0) seen = 1'b1;
            e.en[i] = seen;
        end
        e.en[0] = 1'b1;
        e.cyc   = exp_cyc;
        return e;
    endfunction

    // Compare every valid pulse against the head of the scoreboard
    always @(negedge clk) begin
        if (!reset && bus.valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("spurious_valid", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("bcd_out",   64'(bus.bcd_out),  64'(e.bcd));
                check("digit_en",  64'(bus.digit_en), 64'(e.en));
                check("overflow",  64'(bus.overflow), 64'(e.ovf));
                check("valid_cyc", 64'(cyc),          64'(e.cyc));
            end
        end
    end

    // One conversion with per-cycle busy/valid checks; optional ignored re-start
    task automatic convert(input int unsigned v, input bit poke, input int unsigned poke_v);
        bus.bin_in = BW'(v);
        bus.start  = 1'b1;
        sb_q.push_back(model(v, cyc + 1 + int'(LAT)));
        for (int j = 0; j <= int'(LAT) + 1; j++) begin
            @(negedge clk);
            if (j <= int'(LAT)) begin
                check($sformatf("busy_%0d_j%0d", v, j), 64'(bus.busy), 64'(j < int'(LAT)));
            end
            check($sformatf("valid_%0d_j%0d", v, j), 64'(bus.valid), 64'(j == int'(LAT)));
            bus.start = 1'b0;
            if (j == 5) bus.bin_in = BW'(v ^ 24'h5A5A5);
            if (poke && j == 9) begin
                bus.bin_in = BW'(poke_v);
                bus.start  = 1'b1;
            end
        end
    endtask

    initial begin
        int unsigned cvals[4];
        n_checks   = 0;
        n_fail     = 0;
        cyc        = 0;
        reset      = 1'b1;
        bus.start  = 1'b0;
        bus.bin_in = '0;
        repeat (3) @(negedge clk);
        check("rst_state", 64'({bus.bcd_out, bus.digit_en, bus.busy, bus.valid, bus.overflow}),
              64'({24'h0, 6'b000001, 1'b0, 1'b0, 1'b0}));
        reset = 1'b0;

        // Idle after reset
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check("idle", 64'({bus.bcd_out, bus.digit_en, bus.busy, bus.valid}),
                  64'({24'h0, 6'b000001, 1'b0, 1'b0}));
        end

        convert(123456, 1'b0, 0);
        convert(0, 1'b0, 0);
        convert(7, 1'b0, 0);
        convert(1050, 1'b0, 0);
        convert(999999, 1'b0, 0);
        convert(1000000, 1'b0, 0);
        convert(16777215, 1'b0, 0);
        convert(500, 1'b1, 42);
        convert(98765, 1'b0, 0);

        // Start held high: a new snapshot accepted on each valid edge
        cvals[0] = 314159; cvals[1] = 2718; cvals[2] = 1234567; cvals[3] = 60;
        bus.start  = 1'b1;
        bus.bin_in = BW'(cvals[0]);
        sb_q.push_back(model(cvals[0], cyc + 1 + int'(LAT)));
        for (int n = 1; n < 4; n++) begin
            repeat (13) @(negedge clk);
            bus.bin_in = BW'(24'hABCDEF);
            repeat (int'(LAT) - 12) @(negedge clk);
            bus.bin_in = BW'(cvals[n]);
            sb_q.push_back(model(cvals[n], cyc + 1 + int'(LAT)));
        end
        @(negedge clk);
        bus.start = 1'b0;
        repeat (int'(LAT) + 3) @(negedge clk);
        check("drain_continuous", 64'(sb_q.size()), 64'd0);

        // Reset mid-conversion: no valid, outputs back to reset values
        bus.bin_in = BW'(777777);
        bus.start  = 1'b1;
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (j == 10) reset = 1'b1;
        end
        check("rst_mid", 64'({bus.bcd_out, bus.digit_en, bus.busy, bus.valid, bus.overflow}),
              64'({24'h0, 6'b000001, 1'b0, 1'b0, 1'b0}));
        @(negedge clk);
        reset = 1'b0;
        repeat (int'(LAT) + 3) @(negedge clk);
        check("no_valid_after_abort", 64'(bus.valid), 64'd0);
        check("rst_hold", 64'(bus.bcd_out), 64'd0);
        convert(31, 1'b0, 0);

        check("drain_final", 64'(sb_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, queue %0d expected 0", sb_q.size());
        $fatal(1, "timeout");
    end
endmodule
